// File: rtl/imu_pkg.sv
// ---------------------------------------------------------------------------
// imu_pkg
// Shared definitions for the IMU burst reader:
//   - FSM state encodings (3-bit, exposed on the reader's dbg_state port)
//   - MPU register constants
//   - I2C master read/write direction encodings
//   - clamp_len(): maps a requested burst length to the effective length
// ---------------------------------------------------------------------------
package imu_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_PTR  = 3'd1;
    localparam logic [2:0] ST_WAIT_WR = 3'd2;
    localparam logic [2:0] ST_RD_BYTE = 3'd3;
    localparam logic [2:0] ST_WAIT_RD = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // A zero-length request still reads one byte; oversized requests stop at
    // the buffer depth.
    function automatic int clamp_len(input int req, input int max_bytes);
        if (req == 0) return 1;
        if (req > max_bytes) return max_bytes;
        return req;
    endfunction

endpackage

// File: rtl/imu_sample_buffer.sv
// ---------------------------------------------------------------------------
// imu_sample_buffer
// MAX_BYTES x 8 register file holding the bytes of the latest burst.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset (clears all bytes)
//   we_i              write enable for one byte this cycle
//   waddr_i [AW]      byte index to write (0..MAX_BYTES-1)
//   wdata_i [8]       byte value
//   rd_data_o         flat read-out, byte i at [8*i+7:8*i]
// Bytes that are not written keep their previous contents.
// ---------------------------------------------------------------------------
module imu_sample_buffer #(
    parameter int MAX_BYTES = 14,
    parameter int AW        = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [7:0]             wdata_i,
    output logic [8*MAX_BYTES-1:0] rd_data_o
);

    logic [7:0] mem_q [MAX_BYTES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_BYTES; i++) mem_q[i] <= 8'h00;
        end else if (we_i) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                if (waddr_i == AW'(i)) mem_q[i] <= wdata_i;
            end
        end
    end

    for (genvar g = 0; g < MAX_BYTES; g++) begin : g_flat
        assign rd_data_o[8*g +: 8] = mem_q[g];
    end

endmodule

// File: rtl/imu_burst_reader.sv
// ---------------------------------------------------------------------------
// imu_burst_reader
// Reads len_eff consecutive IMU registers starting at req_reg through the
// byte-level i2c_master request port: for each byte, write the register
// pointer, then read one byte. Optional poll mode re-runs the last request
// every POLL_CYCLES idle cycles.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_start/req_reg/req_len  burst request, sampled only in IDLE
//   poll_en                    auto-restart enable
//   m_start/m_rw/m_addr/       request to i2c_master (m_start is a 1-cycle
//   m_data_in                  pulse; m_rw 1 = read)
//   m_data_out/m_busy/m_done   response from i2c_master
//   rd_data                    sample buffer, byte i at [8*i+7:8*i]
//   rd_valid                   1-cycle pulse when a burst completes
//   busy                       state != IDLE
//   error                      sticky timeout flag, cleared by an accepted req_start
//   byte_count                 bytes stored in the current burst
//   dbg_state                  current FSM state (imu_pkg::ST_*)
// Master handshake: a transfer is launched only when m_busy is low, by a
// single-cycle m_start; it completes on the single-cycle m_done, and m_done
// is only honoured in the WAIT_* states.
// ---------------------------------------------------------------------------
module imu_burst_reader
    import imu_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         MAX_BYTES   = 14,
    parameter int         LEN_W       = 4,
    parameter int         POLL_CYCLES = 100000,
    parameter int         TIMEOUT     = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_start,
    input  logic [7:0]             req_reg,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   poll_en,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data_in,
    input  logic [7:0]             m_data_out,
    input  logic                   m_busy,
    input  logic                   m_done,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   error,
    output logic [LEN_W-1:0]       byte_count,
    output logic [2:0]             dbg_state
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]       state_q, state_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
    logic             m_start_q, m_start_d;
    logic             m_rw_q, m_rw_d;
    logic [7:0]       m_data_in_q, m_data_in_d;
    logic             error_q, error_d;
    logic [LEN_W-1:0] byte_count_q, byte_count_d;

    logic             in_idle, poll_tick, launch, tmo_hit, buf_we;
    logic [LEN_W:0]   idx_next;

    assign in_idle   = (state_q == ST_IDLE);
    assign poll_tick = poll_en && (poll_cnt_q == PW'(POLL_CYCLES - 1));
    // A req_start and a poll tick in the same cycle collapse into one burst.
    assign launch    = in_idle && (req_start || poll_tick);
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign idx_next  = {1'b0, idx_q} + (LEN_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        reg_d        = reg_q;
        len_d        = len_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        poll_cnt_d   = '0;
        m_start_d    = 1'b0;
        m_rw_d       = m_rw_q;
        m_data_in_d  = m_data_in_q;
        error_d      = error_q;
        byte_count_d = byte_count_q;
        buf_we       = 1'b0;

        // Poll counter only runs while idle; it restarts from zero each time.
        if (in_idle && poll_en && !launch) poll_cnt_d = poll_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d      = ST_WR_PTR;
                    idx_d        = '0;
                    byte_count_d = '0;
                    if (req_start) begin
                        reg_d   = req_reg;
                        len_d   = LEN_W'(clamp_len(int'(req_len), MAX_BYTES));
                        error_d = 1'b0;
                    end
                end
            end
            ST_WR_PTR: begin
                if (!m_busy) begin
                    m_start_d   = 1'b1;
                    m_rw_d      = RW_WRITE;
                    m_data_in_d = reg_q + 8'(idx_q);  // wraps 8'hFF -> 8'h00
                    tmo_d       = '0;
                    state_d     = ST_WAIT_WR;
                end
            end
            ST_WAIT_WR: begin
                if (m_done)       state_d = ST_RD_BYTE;
                else if (tmo_hit) begin state_d = ST_ERR; error_d = 1'b1; end
                else              tmo_d = tmo_q + 1'b1;
            end
            ST_RD_BYTE: begin
                if (!m_busy) begin
                    m_start_d = 1'b1;
                    m_rw_d    = RW_READ;
                    tmo_d     = '0;
                    state_d   = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (m_done) begin
                    buf_we       = 1'b1;
                    byte_count_d = idx_next[LEN_W-1:0];
                    if (idx_next < {1'b0, len_q}) begin
                        idx_d   = idx_next[LEN_W-1:0];
                        state_d = ST_WR_PTR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            reg_q        <= 8'h00;
            len_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            poll_cnt_q   <= '0;
            m_start_q    <= 1'b0;
            m_rw_q       <= 1'b0;
            m_data_in_q  <= 8'h00;
            error_q      <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            reg_q        <= reg_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            poll_cnt_q   <= poll_cnt_d;
            m_start_q    <= m_start_d;
            m_rw_q       <= m_rw_d;
            m_data_in_q  <= m_data_in_d;
            error_q      <= error_d;
            byte_count_q <= byte_count_d;
        end
    end

    imu_sample_buffer #(
        .MAX_BYTES (MAX_BYTES),
        .AW        (LEN_W)
    ) u_buf (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (buf_we),
        .waddr_i   (idx_q),
        .wdata_i   (m_data_out),
        .rd_data_o (rd_data)
    );

    assign m_start    = m_start_q;
    assign m_rw       = m_rw_q;
    assign m_addr     = DEV_ADDR;
    assign m_data_in  = m_data_in_q;
    assign rd_valid   = (state_q == ST_DONE);
    assign busy       = !in_idle;
    assign error      = error_q;
    assign byte_count = byte_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imu_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_imu_burst_reader
// Self-checking bench: behavioural i2c_master with fixed 20-cycle transfers
// backed by a 256-byte register map, directed vector table, hand-written
// corner sequences (timeout, poll, reset mid-burst, stray m_done) and random
// bursts checked against a register-map reference model.
// ---------------------------------------------------------------------------
module tb_imu_burst_reader;

    localparam int MAXB    = 14;
    localparam int LW      = 4;
    localparam int POLL    = 50;
    localparam int TMO     = 100;
    localparam int XFER    = 20;
    localparam int BUDGET  = 2000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_start;
    logic [7:0]        req_reg;
    logic [LW-1:0]     req_len;
    logic              poll_en;
    logic              m_start, m_rw;
    logic [6:0]        m_addr;
    logic [7:0]        m_data_in, m_data_out;
    logic              m_busy, m_done;
    logic [8*MAXB-1:0] rd_data;
    logic              rd_valid, busy, error;
    logic [LW-1:0]     byte_count;
    logic [2:0]        dbg_state;

    imu_burst_reader #(
        .DEV_ADDR(7'h68), .MAX_BYTES(MAXB), .LEN_W(LW),
        .POLL_CYCLES(POLL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_reg(req_reg),
        .req_len(req_len), .poll_en(poll_en), .m_start(m_start), .m_rw(m_rw),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_busy(m_busy), .m_done(m_done), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .error(error), .byte_count(byte_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc_n = 0;
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // ---------------- behavioural i2c master ----------------
    logic [7:0] mem [256];
    logic [8:0] act_q [$];      // every m_start seen: {m_rw, m_data_in}
    int         hang_abs = -1;  // act_q index of a start that never completes
    int         hang_cyc = 0;
    int         spur_cnt = 0;

    initial begin
        int         xfer_left;
        int         spur_seen;
        logic [7:0] ptr;
        logic       is_read;
        xfer_left = 0; spur_seen = 0; ptr = 8'h00; is_read = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (!rst_n) begin
                m_busy = 1'b0;
                xfer_left = 0;
            end else begin
                if (spur_seen != spur_cnt) begin
                    spur_seen++;
                    m_done = 1'b1;
                    m_data_out = 8'hA5;
                end
                if (m_start) begin
                    act_q.push_back({m_rw, m_data_in});
                    is_read = m_rw;
                    if (!m_rw) ptr = m_data_in;
                    if (act_q.size() - 1 == hang_abs) hang_cyc = cyc_n;
                    else begin m_busy = 1'b1; xfer_left = XFER; end
                end else if (xfer_left > 0) begin
                    xfer_left--;
                    if (xfer_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_data_out = is_read ? mem[ptr] : 8'h00;
                    end
                end
            end
        end
    end

    // ---------------- rd_valid monitor ----------------
    int rv_cycles = 0;
    int rv_times [$];
    initial forever begin
        @(negedge clk);
        if (rd_valid === 1'b1) begin
            rv_cycles++;
            rv_times.push_back(cyc_n);
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [8*MAXB-1:0] exp_rd = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_len(input int len);
        if (len == 0) return 1;
        if (len > MAXB) return MAXB;
        return len;
    endfunction

    // Expected master traffic: reps x (write ptr, read) per byte.
    task automatic check_starts(input string name, input int base, input logic [7:0] rg,
                                input int leff, input int reps);
        logic [8:0] exp_q [$];
        logic [8:0] e;
        int ok;
        int j;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < leff; i++) begin
                exp_q.push_back({1'b0, 8'(rg + i)});
                exp_q.push_back({1'b1, 8'h00});
            end
        check({name, "_nstarts"}, 128'(act_q.size() - base), 128'(exp_q.size()));
        ok = 1; j = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (j >= act_q.size()) ok = 0;
            else if (e[8] ? (act_q[j][8] !== 1'b1) : (act_q[j] !== e)) ok = 0;
            j++;
        end
        check({name, "_start_seq"}, 128'(ok), 128'(1));
    endtask

    // ---------------- drivers ----------------
    task automatic start_req(input logic [7:0] rg, input logic [LW-1:0] len);
        @(negedge clk);
        req_reg = rg; req_len = len; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        if (c >= BUDGET) check({name, "_idle_budget"}, 128'(0), 128'(1));
    endtask

    task automatic run_and_check(input string name, input logic [7:0] rg,
                                 input logic [LW-1:0] len, input int leff);
        int base, rv0;
        base = act_q.size(); rv0 = rv_cycles;
        for (int i = 0; i < leff; i++) exp_rd[8*i +: 8] = mem[8'(rg + i)];
        start_req(rg, len);
        wait_idle(name);
        @(negedge clk);
        check({name, "_rd_valid"}, 128'(rv_cycles - rv0), 128'(1));
        check({name, "_rd_data"}, 128'(rd_data), 128'(exp_rd));
        check({name, "_byte_count"}, 128'(byte_count), 128'(leff));
        check({name, "_error"}, 128'(error), 128'(0));
        check_starts(name, base, rg, leff, 1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] rg;
        logic [3:0] len;
        int         exp_len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base, rv0, c, err_cyc, iv1, iv2;
        logic [7:0] rg;
        logic [LW-1:0] ln;
        logic [8*MAXB-1:0] snap;
        logic [LW-1:0] bc_snap;

        vecs[0] = '{"who_am_i",  8'h75, 4'd1,  1};
        vecs[1] = '{"full",      8'h3B, 4'd14, 14};
        vecs[2] = '{"len0",      8'h10, 4'd0,  1};
        vecs[3] = '{"wrap",      8'hFE, 4'd3,  3};
        vecs[4] = '{"clamp15",   8'h20, 4'd15, 14};
        vecs[5] = '{"mid",       8'h00, 4'd5,  5};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h75] = 8'h68;

        // ---- reset ----
        rst_n = 1'b0; req_start = 1'b0; req_reg = 8'h00; req_len = '0; poll_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 128'({m_start, m_rw, m_data_in, rd_valid, busy, error, byte_count}), 128'(0));
        check("reset_rd_data", 128'(rd_data), 128'(0));
        check("m_addr", 128'(m_addr), 128'(7'h68));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- directed vector table ----
        foreach (vecs[k]) run_and_check(vecs[k].name, vecs[k].rg, vecs[k].len, vecs[k].exp_len);

        // ---- stray m_done while idle is ignored ----
        snap = rd_data; bc_snap = byte_count; rv0 = rv_cycles;
        spur_cnt++;
        repeat (3) @(negedge clk);
        spur_cnt++;
        repeat (5) @(negedge clk);
        check("stray_done_busy", 128'(busy), 128'(0));
        check("stray_done_state", 128'({rd_data, byte_count}), 128'({snap, bc_snap}));
        check("stray_done_rv", 128'(rv_cycles - rv0), 128'(0));

        // ---- timeout on the pointer write of byte 2 ----
        base = act_q.size(); rv0 = rv_cycles;
        hang_abs = base + 2;
        exp_rd[7:0] = mem[8'h40];
        start_req(8'h40, 4'd4);
        c = 0;
        while (error !== 1'b1 && c < BUDGET) begin @(negedge clk); c++; end
        err_cyc = cyc_n;
        check("tmo_error", 128'(error), 128'(1));
        check("tmo_cycles_ok", 128'((err_cyc - hang_cyc >= TMO) && (err_cyc - hang_cyc <= TMO + 1)), 128'(1));
        @(negedge clk);
        check("tmo_busy", 128'(busy), 128'(0));
        repeat (10) @(negedge clk);
        check("tmo_sticky", 128'(error), 128'(1));
        check("tmo_no_rv", 128'(rv_cycles - rv0), 128'(0));
        check("tmo_byte_count", 128'(byte_count), 128'(1));
        check("tmo_rd_data", 128'(rd_data), 128'(exp_rd));
        hang_abs = -1;
        run_and_check("after_tmo", 8'h41, 4'd2, 2);

        // ---- poll mode ----
        run_and_check("poll_setup", ACCEL_REG(), 4'd2, 2);
        base = act_q.size(); rv0 = rv_cycles;
        @(negedge clk);
        poll_en = 1'b1;
        c = 0;
        while (busy !== 1'b1 && c < BUDGET) begin @(negedge clk); c++; end
        // request during a burst must be dropped
        req_reg = 8'h99; req_len = 4'd5; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        c = 0;
        while (rv_cycles - rv0 < 3 && c < 3 * BUDGET) begin @(negedge clk); c++; end
        poll_en = 1'b0;
        wait_idle("poll");
        repeat (2 * POLL) @(negedge clk);
        check("poll_rv_count", 128'(rv_cycles - rv0), 128'(3));
        check_starts("poll", base, 8'h3B, 2, 3);
        check("poll_rd_data", 128'(rd_data), 128'(exp_rd));
        if (rv_times.size() >= 3) begin
            iv1 = rv_times[rv_times.size()-2] - rv_times[rv_times.size()-3];
            iv2 = rv_times[rv_times.size()-1] - rv_times[rv_times.size()-2];
        end else begin
            iv1 = 0; iv2 = 0;
        end
        check("poll_interval_min", 128'(iv2 > POLL), 128'(1));
        check("poll_interval_steady", 128'(iv2), 128'(iv1));

        // ---- reset during WAIT_RD ----
        base = act_q.size();
        start_req(8'h50, 4'd3);
        c = 0;
        while (act_q.size() < base + 2 && c < BUDGET) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 128'({m_start, m_rw, m_data_in, rd_valid, busy, error, byte_count}), 128'(0));
        check("rst_mid_rd_data", 128'(rd_data), 128'(0));
        exp_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_and_check("after_rst", 8'h50, 4'd3, 3);

        // ---- random bursts against the register-map model ----
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            rg = 8'($urandom_range(0, 255));
            ln = LW'($urandom_range(0, 15));
            run_and_check($sformatf("rand%0d", n), rg, ln, ref_len(int'(ln)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    function automatic logic [7:0] ACCEL_REG();
        return 8'h3B;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
